key_conditioner: RTL

- Front-end stage for the accumulator datapath (adder2).
- Takes raw, bouncy, asynchronous active-low push-buttons (KEY) and slide switches (SW) from the board.
- Delivers synchronized, debounced, active-high levels and single-cycle press pulses.
- Run_Accumulate and Reset_Clear of the adder therefore see exactly one clean event per physical press.

---
 rtl/key_cond_pkg.sv | 13 +
 rtl/key_conditioner_if.sv | 22 ++
 rtl/key_debounce_cell.sv | 116 +++++++++++
 rtl/key_conditioner.sv | 52 +++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and simulation-scale timing constants for the key conditioner.
package key_cond_pkg;

    localparam int SIM_DEBOUNCE      = 4;
    localparam int SIM_REPEAT_DELAY  = 16;
    localparam int SIM_REPEAT_PERIOD = 6;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_HELD     = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Board-facing raw inputs and conditioned outputs of key_conditioner.
interface key_conditioner_if #(
    parameter int N_KEY = 2,
    parameter int SW_W  = 10
);
    logic [N_KEY-1:0] KEY;
    logic [SW_W-1:0]  SW;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic [SW_W-1:0]  sw_sync;

    modport master (
        output KEY, SW,
        input  key_level, key_press, key_release, sw_sync
    );

    modport slave (
        input  KEY, SW,
        output key_level, key_press, key_release, sw_sync
    );
endinterface

// File: rtl/key_debounce_cell.sv
// One key: 2-flop sync, debounce counter, held level, press/release pulses.
// Optional auto-repeat on held keys when KEY_AUTOREPEAT_EN is defined.
module key_debounce_cell
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             press_reg, press_next, release_reg, release_next;
    logic             edge_press, rpt_fire, pressed;

    assign pressed = ~sync2_reg;

    // Sync flops reset to "released" so no false press appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            state_reg   <= KEY_RELEASED;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync1_reg   <= key_raw;
            sync2_reg   <= sync1_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        edge_press   = 1'b0;
        release_next = 1'b0;
        if (pressed == (state_reg == KEY_HELD)) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            if (pressed) begin
                state_next = KEY_HELD;
                edge_press = 1'b1;
            end else begin
                state_next   = KEY_RELEASED;
                release_next = 1'b1;
            end
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             rpt_first_reg, rpt_first_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_reg   <= '0;
            rpt_first_reg <= 1'b1;
        end else begin
            rpt_cnt_reg   <= rpt_cnt_next;
            rpt_first_reg <= rpt_first_next;
        end
    end

    // Counting restarts at every fresh press and stops as soon as the key drops.
    always_comb begin
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_first_next = rpt_first_reg;
        rpt_fire       = 1'b0;
        if (state_next != KEY_HELD || state_reg != KEY_HELD) begin
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b1;
        end else if (rpt_first_reg && rpt_cnt_reg == DELAY_LAST) begin
            rpt_fire       = 1'b1;
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b0;
        end else if (!rpt_first_reg && rpt_cnt_reg == PERIOD_LAST) begin
            rpt_fire     = 1'b1;
            rpt_cnt_next = '0;
        end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
        end
    end
`else
    // Repeat compiled out: this is 0 for every legal configuration.
    assign rpt_fire = (REPEAT_DELAY < 1) && (REPEAT_PERIOD < 1);
`endif

    assign press_next    = edge_press | rpt_fire;
    assign level         = (state_reg == KEY_HELD);
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board keys/switches into clean levels and press/release pulses.
// Build option: define KEY_AUTOREPEAT_EN to enable held-key auto-repeat.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEY           = 2,
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             Clk,
    input  logic             Reset,
    key_conditioner_if.slave bus
);
    logic [N_KEY-1:0] level_w, press_w, release_w;
    logic [SW_W-1:0]  sw_sync1_reg, sw_sync2_reg;

    generate
        for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
            key_debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_cell (
                .clk           (Clk),
                .rst_n         (Reset),
                .key_raw       (bus.KEY[gi]),
                .level         (level_w[gi]),
                .press_pulse   (press_w[gi]),
                .release_pulse (release_w[gi])
            );
        end
    endgenerate

    // Switches are static in use, so synchronising them is enough.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sw_sync1_reg <= '0;
            sw_sync2_reg <= '0;
        end else begin
            sw_sync1_reg <= bus.SW;
            sw_sync2_reg <= sw_sync1_reg;
        end
    end

    assign bus.key_level   = level_w;
    assign bus.key_press   = press_w;
    assign bus.key_release = release_w;
    assign bus.sw_sync     = sw_sync2_reg;

endmodule
